// File: rtl/vga_rect_fill.sv
// Rectangle filler for the 160x120 VGA plot slave.
// The CPU writes origin, size and colour over the slave port, then starts the
// fill. The block clips the rectangle to the screen and walks it in row-major
// order, issuing one pixel-plot write per pixel on the master port.
module vga_rect_fill #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        read,
    output logic [31:0] readdata,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [3:0]  m_address,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    output logic        done
);

    localparam logic [8:0] SW = 9'(SCREEN_W);
    localparam logic [8:0] SH = 9'(SCREEN_H);

    typedef enum logic [1:0] {IDLE, SETUP, EMIT} state_t;

    state_t      state, state_nxt;
    logic [7:0]  x0, w, colour, cx;
    logic [6:0]  y0, h, cy;
    logic [8:0]  xe, ye;
    logic [15:0] count;
    logic        start, accept, last_col, last_row, empty, fill_end;
    logic [8:0]  x_sum, y_sum;

    // Only the coordinate and colour fields of writedata are meaningful.
    logic unused_ok;
    assign unused_ok = &{1'b0, writedata[31], writedata[15:8]};

    // 9-bit sums so that x0+w / y0+h never wrap before clipping
    assign x_sum    = {1'b0, x0} + {1'b0, w};
    assign y_sum    = {2'b0, y0} + {2'b0, h};
    assign empty    = (w == 8'd0) || (h == 7'd0) ||
                      ({1'b0, x0} >= SW) || ({2'b0, y0} >= SH);
    assign start    = write && (address == 4'd0) && (state == IDLE);
    assign accept   = (state == EMIT) && !m_waitrequest;
    assign last_col = ({1'b0, cx} + 9'd1) >= xe;
    assign last_row = ({2'b0, cy} + 9'd1) >= ye;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETUP;
            SETUP:   state_nxt = empty ? IDLE : EMIT;
            EMIT:    if (accept && last_col && last_row) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: master request and end-of-fill detect
    always_comb begin
        m_address   = 4'd0;
        m_write     = (state == EMIT);
        m_writedata = {1'b0, cy, cx, 8'h00, colour};
        fill_end    = ((state == SETUP) && empty) ||
                      (accept && last_col && last_row);
    end

    // done is a registered one-cycle pulse following the final transition
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) done <= 1'b0;
        else          done <= fill_end;
    end

    // Configuration registers; writes only land while idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x0     <= '0;
            y0     <= '0;
            w      <= '0;
            h      <= '0;
            colour <= '0;
        end else if (write && state == IDLE) begin
            case (address)
                4'd1: begin
                    x0 <= writedata[23:16];
                    y0 <= writedata[30:24];
                end
                4'd2: begin
                    w <= writedata[23:16];
                    h <= writedata[30:24];
                end
                4'd3:    colour <= writedata[7:0];
                default: ;
            endcase
        end
    end

    // Walk cursor and clipped bounds; cursor advances only on accepted pixels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cx <= '0;
            cy <= '0;
            xe <= '0;
            ye <= '0;
        end else if (state == SETUP) begin
            cx <= x0;
            cy <= y0;
            xe <= (x_sum < SW) ? x_sum : SW;
            ye <= (y_sum < SH) ? y_sum : SH;
        end else if (accept) begin
            if (!last_col) begin
                cx <= cx + 8'd1;
            end else begin
                cx <= x0;
                cy <= cy + 7'd1;
            end
        end
    end

    // Pixel counter: cleared by start, bumped per accepted pixel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    count <= '0;
        else if (start)  count <= '0;
        else if (accept) count <= count + 16'd1;
    end

    // Registered slave read data, held between reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (read) begin
            case (address)
                4'd0:    readdata <= {31'b0, state != IDLE};
                4'd1:    readdata <= {1'b0, y0, x0, 16'b0};
                4'd2:    readdata <= {1'b0, h, w, 16'b0};
                4'd3:    readdata <= {24'b0, colour};
                4'd4:    readdata <= {16'b0, count};
                default: readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill: expected pixel words go into a queue
// when a fill is set up and are popped as the master port issues writes.
module tb_vga_rect_fill;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  address;
    logic        read;
    logic [31:0] readdata;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  m_address;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_waitrequest;
    logic        done;

    vga_rect_fill dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .readdata      (readdata),
        .write         (write),
        .writedata     (writedata),
        .m_address     (m_address),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest),
        .done          (done)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          acc_cnt = 0;
    int          first_mw_cyc = 0;
    bit          mw_seen = 0;
    int          last_set_cyc = 0;
    int          start_cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rdv;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Master-side monitor: score every request against the queue head
    always @(negedge clk) begin
        if (m_write) begin
            if (!mw_seen) begin
                mw_seen = 1;
                first_mw_cyc = cyc;
            end
            if (exp_q.size() == 0) begin
                check("write_with_empty_queue", exp_q.size(), 1);
            end else if (m_waitrequest) begin
                check("stall_hold", m_writedata, exp_q[0]);
            end else begin
                check("pixel", m_writedata, exp_q.pop_front());
                check("m_address", {28'b0, m_address}, 0);
                acc_cnt++;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic logic [31:0] pack(input int x, input int y);
        logic [7:0] xb;
        logic [6:0] yb;
        xb = x[7:0];
        yb = y[6:0];
        return {1'b0, yb, xb, 16'h0};
    endfunction

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        address = a; writedata = d; write = 1'b1;
        last_set_cyc = cyc;
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        address = a; read = 1'b1;
        @(posedge clk); #1;
        read = 1'b0;
        d = readdata;
    endtask

    task automatic start_fill();
        wr(4'd0, 32'h0);
        start_cyc = last_set_cyc;
    endtask

    task automatic config_rect(input int x, input int y, input int w, input int h, input int col);
        wr(4'd1, pack(x, y));
        wr(4'd2, pack(w, h));
        wr(4'd3, 32'(col & 255));
    endtask

    // Reference model: clipped row-major walk
    task automatic push_rect(input int x, input int y, input int w, input int h, input int col);
        int xe, ye;
        xe = (x + w < 160) ? x + w : 160;
        ye = (y + h < 120) ? y + h : 120;
        for (int yy = y; yy < ye; yy++)
            for (int xx = x; xx < xe; xx++)
                exp_q.push_back(pack(xx, yy) | 32'(col & 255));
    endtask

    // Bounded wait for the done pulse, then score pulse count, latency, drain
    task automatic wait_fill(input string tag, input int exp_lat);
        int d;
        d = done_cnt;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (done_cnt != d) break;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_pulses"}, done_cnt - d, 1);
        check({tag, "_done_latency"}, done_cyc - start_cyc, exp_lat);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int a0;
        reset_n = 1'b0; address = '0; read = 1'b0; write = 1'b0;
        writedata = '0; m_waitrequest = 1'b0;
        #1;
        check("rst_m_write", {31'b0, m_write}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_readdata", readdata, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Unclipped 3x2 fill
        config_rect(10, 20, 3, 2, 8'h5A);
        exp_q.push_back(32'h140A005A); exp_q.push_back(32'h140B005A);
        exp_q.push_back(32'h140C005A); exp_q.push_back(32'h150A005A);
        exp_q.push_back(32'h150B005A); exp_q.push_back(32'h150C005A);
        mw_seen = 0;
        start_fill();
        wait_fill("unclipped", 8);
        check("first_m_write_latency", first_mw_cyc - start_cyc, 2);
        rd(4'd4, rdv); check("unclipped_count", rdv, 6);
        rd(4'd0, rdv); check("unclipped_ctrl", rdv, 0);

        // Restart repeats the same rectangle
        push_rect(10, 20, 3, 2, 8'h5A);
        start_fill();
        wait_fill("restart", 8);

        // Clipped at bottom-right corner
        config_rect(158, 118, 5, 5, 8'h0F);
        push_rect(158, 118, 5, 5, 8'h0F);
        start_fill();
        wait_fill("clip", 6);
        rd(4'd4, rdv); check("clip_count", rdv, 4);

        // Empty: zero width
        config_rect(3, 3, 0, 7, 8'h01);
        start_fill();
        wait_fill("empty_w0", 2);
        rd(4'd4, rdv); check("empty_w0_count", rdv, 0);

        // Empty: origin off screen
        config_rect(200, 3, 3, 2, 8'h01);
        start_fill();
        wait_fill("empty_x200", 2);
        rd(4'd4, rdv); check("empty_x200_count", rdv, 0);

        // Backpressure: 2x1 unstalled, then stalled 3 cycles on pixel 2
        config_rect(5, 5, 2, 1, 8'h11);
        push_rect(5, 5, 2, 1, 8'h11);
        start_fill();
        wait_fill("nostall", 4);
        push_rect(5, 5, 2, 1, 8'h11);
        a0 = acc_cnt;
        start_fill();
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_waitrequest = 1'b1;
        repeat (3) @(posedge clk);
        #1 m_waitrequest = 1'b0;
        wait_fill("stall", 7);
        check("stall_pixels", acc_cnt - a0, 2);

        // Busy lockout: config writes and restart during EMIT are ignored
        config_rect(10, 20, 8, 1, 8'h33);
        push_rect(10, 20, 8, 1, 8'h33);
        start_fill();
        wr(4'd1, 32'h0);
        wr(4'd3, 32'hFF);
        wr(4'd0, 32'h0);
        rd(4'd0, rdv); check("busy_ctrl", rdv, 1);
        wait_fill("lockout", 10);
        rd(4'd0, rdv); check("idle_ctrl", rdv, 0);
        rd(4'd1, rdv); check("lockout_origin", rdv, pack(10, 20));
        rd(4'd3, rdv); check("lockout_colour", rdv, 32'h33);

        // Asynchronous reset after two pixels of a 4x4 fill
        config_rect(0, 0, 4, 4, 8'h77);
        push_rect(0, 0, 4, 4, 8'h77);
        a0 = acc_cnt;
        start_fill();
        for (int i = 0; i < 50; i++) begin
            if (acc_cnt - a0 >= 2) break;
            @(posedge clk); #1;
        end
        check("pre_reset_pixels", acc_cnt - a0, 2);
        #2 reset_n = 1'b0;
        #1;
        check("async_m_write_drop", {31'b0, m_write}, 0);
        check("async_readdata", readdata, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(posedge clk);
        rd(4'd0, rdv); check("post_rst_ctrl", rdv, 0);
        rd(4'd1, rdv); check("post_rst_origin", rdv, 0);
        rd(4'd2, rdv); check("post_rst_size", rdv, 0);
        rd(4'd3, rdv); check("post_rst_colour", rdv, 0);
        rd(4'd4, rdv); check("post_rst_count", rdv, 0);
        rd(4'd9, rdv); check("unmapped_read", rdv, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
